// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared op encodings, FSM states and iteration count for muldiv_unit
package muldiv_pkg;

    localparam int ITER = 32;

    typedef enum logic [1:0] {
        MULT  = 2'b00,
        MULTU = 2'b01,
        DIV   = 2'b10,
        DIVU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        FIX  = 2'b10,
        DONE = 2'b11
    } state_e;

endpackage

// File: rtl/muldiv_if.sv
// rtl/muldiv_if.sv - request/result bundle between execute stage and muldiv_unit
interface muldiv_if #(
    parameter int WIDTH = 32
);
    logic                 start;
    logic [1:0]           op;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 busy;
    logic                 done;
    logic                 hilo_we;
    logic [2*WIDTH-1:0]   result;

    modport master (
        output start, op, a, b,
        input  busy, done, hilo_we, result
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, hilo_we, result
    );
endinterface

// File: rtl/muldiv_div_step.sv
// rtl/muldiv_div_step.sv - one combinational restoring-divide step (module div_step)
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic [WIDTH-1:0] quo_i,
    input  logic [WIDTH-1:0] dvs_i,
    output logic [WIDTH-1:0] rem_o,
    output logic [WIDTH-1:0] quo_o
);
    logic [WIDTH:0] rem_sh;
    logic [WIDTH:0] trial;

    // The shifted remainder can exceed WIDTH bits for large unsigned divisors;
    // trial[WIDTH] is the borrow because |rem_sh - dvs| always fits in WIDTH bits.
    assign rem_sh = {rem_i, quo_i[WIDTH-1]};
    assign trial  = rem_sh - {1'b0, dvs_i};
    assign rem_o  = trial[WIDTH] ? rem_sh[WIDTH-1:0] : trial[WIDTH-1:0];
    assign quo_o  = {quo_i[WIDTH-2:0], ~trial[WIDTH]};
endmodule

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative 32-bit multiply/divide producing {hi, lo}
// Divide datapath is compiled only when MULDIV_DIV_EN is defined.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic     clk,
    input  logic     rst,
    muldiv_if.slave  bus
);
    localparam int CW = $clog2(ITER);

    state_e               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [1:0]           op_q, op_d;
    logic                 neg_q, neg_d;
    logic [WIDTH-1:0]     opb_q, opb_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [2*WIDTH-1:0]   result_q, result_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 we_q, we_d;

    logic                 a_neg, b_neg;
    logic [WIDTH-1:0]     a_mag, b_mag;
    logic [WIDTH:0]       mul_sum;

`ifdef MULDIV_DIV_EN
    logic                 neg_rem_q, neg_rem_d;
    logic                 bzero_q, bzero_d;
    logic [WIDTH-1:0]     rem_nx, quo_nx;
    logic [WIDTH-1:0]     rem_fix, quo_fix;

    div_step #(.WIDTH(WIDTH)) u_div_step (
        .rem_i (acc_q[2*WIDTH-1:WIDTH]),
        .quo_i (acc_q[WIDTH-1:0]),
        .dvs_i (opb_q),
        .rem_o (rem_nx),
        .quo_o (quo_nx)
    );
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        neg_d    = neg_q;
        opb_d    = opb_q;
        acc_d    = acc_q;
        result_d = result_q;
`ifdef MULDIV_DIV_EN
        neg_rem_d = neg_rem_q;
        bzero_d   = bzero_q;
        rem_fix   = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
        quo_fix   = bzero_q ? {WIDTH{1'b1}}
                            : (neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0]);
`endif
        // op[0]=0 marks the signed variants
        a_neg   = ~bus.op[0] & bus.a[WIDTH-1];
        b_neg   = ~bus.op[0] & bus.b[WIDTH-1];
        a_mag   = a_neg ? -bus.a : bus.a;
        b_mag   = b_neg ? -bus.b : bus.b;
        mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    op_d  = bus.op;
                    neg_d = a_neg ^ b_neg;
                    cnt_d = '0;
                    // multiplicand or divisor in opb; multiplier or dividend in acc low half
                    opb_d = bus.op[1] ? b_mag : a_mag;
                    acc_d = {{WIDTH{1'b0}}, (bus.op[1] ? a_mag : b_mag)};
`ifdef MULDIV_DIV_EN
                    neg_rem_d = a_neg;
                    bzero_d   = (bus.b == '0);
                    state_d   = RUN;
`else
                    state_d   = bus.op[1] ? DONE : RUN;
`endif
                end
            end
            RUN: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(ITER - 1)) begin
                    state_d = FIX;
                end
`ifdef MULDIV_DIV_EN
                acc_d = op_q[1] ? {rem_nx, quo_nx} : {mul_sum, acc_q[WIDTH-1:1]};
`else
                acc_d = {mul_sum, acc_q[WIDTH-1:1]};
`endif
            end
            FIX: begin
                state_d  = DONE;
                result_d = neg_q ? -acc_q : acc_q;
`ifdef MULDIV_DIV_EN
                if (op_q[1]) begin
                    result_d = {rem_fix, quo_fix};
                end
`endif
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
`ifdef MULDIV_DIV_EN
        we_d   = done_d;
`else
        we_d   = done_d & ~op_d[1];
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            neg_q    <= 1'b0;
            opb_q    <= '0;
            acc_q    <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            we_q     <= 1'b0;
`ifdef MULDIV_DIV_EN
            neg_rem_q <= 1'b0;
            bzero_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            neg_q    <= neg_d;
            opb_q    <= opb_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            we_q     <= we_d;
`ifdef MULDIV_DIV_EN
            neg_rem_q <= neg_rem_d;
            bzero_q   <= bzero_d;
`endif
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.hilo_we = we_q;
    assign bus.result  = result_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - directed and random checks of muldiv_unit against an arithmetic model
module tb_muldiv_unit;
    import muldiv_pkg::*;

`ifdef MULDIV_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    int   n_vec  = 0;
    int   n_fail = 0;
    logic [63:0] last_res = '0;

    always #5 clk = ~clk;

    muldiv_if #(.WIDTH(32)) bus ();

    muldiv_unit #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb, q, r;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        case (op)
            2'b00:   return sa * sb;
            2'b01:   return {32'b0, a} * {32'b0, b};
            2'b10: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            default: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
        endcase
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input bit poke);
        logic [63:0] exp_res;
        bit has_res, we_early, busy_drop;
        int exp_lat, lat;
        has_res  = DIV_EN || !op[1];
        exp_lat  = has_res ? 34 : 1;
        exp_res  = has_res ? model(op, a, b) : last_res;
        we_early = 0;
        busy_drop = 0;
        chk("idle_before_start", bus.busy, 0);
        bus.start = 1'b1;
        bus.op = op;
        bus.a = a;
        bus.b = b;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.op = $urandom_range(0, 3);
        bus.a = $urandom;
        bus.b = $urandom;
        lat = 1;
        while (!bus.done && lat < 60) begin
            if (bus.hilo_we) we_early = 1;
            if (!bus.busy) busy_drop = 1;
            bus.start = (poke && lat == 5);
            @(posedge clk); #1;
            lat++;
        end
        bus.start = poke;
        chk("latency", lat, exp_lat);
        chk("busy_during_op", busy_drop, 0);
        chk("no_early_we", we_early, 0);
        chk("busy_at_done", bus.busy, 1);
        chk("hilo_we_at_done", bus.hilo_we, has_res);
        chk("result", bus.result, exp_res);
        @(posedge clk); #1;
        bus.start = 1'b0;
        chk("done_one_cycle", bus.done, 0);
        chk("we_one_cycle", bus.hilo_we, 0);
        chk("busy_cleared", bus.busy, 0);
        chk("result_held", bus.result, exp_res);
        last_res = exp_res;
    endtask

    task automatic reset_mid_op();
        bit seen;
        bus.start = 1'b1;
        bus.op = MULTU;
        bus.a = $urandom | 32'h1;
        bus.b = $urandom | 32'h1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (9) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_we", bus.hilo_we, 0);
        chk("rst_result", bus.result, 0);
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (bus.hilo_we || bus.done || bus.busy) seen = 1;
        end
        chk("rst_no_late_we", seen, 0);
        last_res = '0;
    endtask

    initial begin
        rst = 1'b1;
        bus.start = 1'b0;
        bus.op = '0;
        bus.a = '0;
        bus.b = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset_busy", bus.busy, 0);
        chk("reset_done", bus.done, 0);
        chk("reset_we", bus.hilo_we, 0);
        chk("reset_result", bus.result, 0);

        run_op(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_op(MULT,  32'hFFFF_FFFD, 32'd7, 0);
        run_op(MULT,  32'h8000_0000, 32'h8000_0000, 0);
        run_op(DIV,   32'hFFFF_FFF9, 32'd2, 0);
        run_op(DIVU,  32'd100, 32'd7, 0);
        run_op(DIV,   32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_op(DIVU,  32'h1234, 32'd0, 0);
        run_op(DIV,   32'hFFFF_FF00, 32'd0, 0);
        run_op(DIVU,  32'hFFFF_FFFF, 32'h8000_0001, 0);
        run_op(MULTU, $urandom, $urandom, 1);
        run_op(MULT,  $urandom, $urandom, 0);

        for (int i = 0; i < 24; i++) begin
            logic [1:0]  rop;
            logic [31:0] ra, rb;
            rop = $urandom_range(0, 3);
            ra  = $urandom;
            rb  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 3) == 0) rb = rb >> $urandom_range(1, 31);
            run_op(rop, ra, rb, ($urandom_range(0, 4) == 0));
        end

        reset_mid_op();
        run_op(MULT, $urandom, $urandom, 0);
        run_op(DIV, $urandom, $urandom_range(1, 1000), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative 32-bit multiply/divide unit that produces the 64-bit {hi, lo} result consumed by the register file's hi/lo pair. It accepts an operation from the decode/execute stage with a start pulse, runs a fixed-latency shift-add multiply or restoring divide, and issues a single-cycle hi/lo write strobe with the 64-bit result. It writes the hi/lo pair that the register file reads back through mfhi/mflo.

## Interface
Parameters:
- WIDTH, 32, operand width; result is 2*WIDTH.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only while busy=0.
- op  in  2  operation: MULT, MULTU, DIV, DIVU (encodings in muldiv_pkg).
- a  in  WIDTH  operand A: multiplicand or dividend.
- b  in  WIDTH  operand B: multiplier or divisor.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  single-cycle completion pulse.
- hilo_we  out  1  hi/lo write strobe to the register file; equals done except for the case under Configuration.
- result  out  2*WIDTH  {hi, lo}; multiply: hi=product[63:32], lo=product[31:0]; divide: hi=remainder, lo=quotient.

## Operation
- States: IDLE, RUN, FIX, DONE.
- IDLE: start=1 latches op, |a| and |b| (signed ops) or raw a and b (unsigned ops), and the result signs, then goes to RUN. Iteration counter is cleared.
- RUN: one iteration per cycle for 32 cycles, then goes to FIX.
  - Multiply step: radix-2 shift-add into a 64-bit accumulator.
  - Divide step: one restoring subtract-shift step into a 32-bit remainder and a 32-bit quotient.
- FIX: applies two's-complement sign correction.
  - Product is negated if sign(a)^sign(b).
  - Quotient is negated if sign(a)^sign(b).
  - Remainder takes the sign of the dividend.
  - Goes to DONE.
- DONE: done=1 and hilo_we=1 for exactly one cycle. result is valid and is held until the next accepted start. Goes to IDLE.
- start while busy=1 is ignored; no queueing.
- Divide by zero (b=0): lo=0xFFFFFFFF, hi=a. This holds for signed and unsigned ops. Latency is unchanged.
- Signed overflow, DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- Widths: all internal arithmetic is unsigned on magnitudes. The 33-bit trial subtract detects borrow.

## Timing
- Start sampled in cycle N. busy=1 during cycles N+1..N+34. done/hilo_we=1 in cycle N+34. busy=0 and a new start is accepted in cycle N+35.
- Fixed latency of 34 cycles for all ops, including divide by zero.
- start may be asserted in the same cycle done is high. It is not accepted, because busy=1 in that cycle.
- Reset values: busy=0, done=0, hilo_we=0, result=0, state=IDLE.
- rst mid-operation: the next cycle is IDLE with all outputs at reset values. No hilo_we is issued for the aborted op.
- Operands a, b and op need only be stable in the start cycle.

## Configuration
- MULDIV_DIV_EN defined: full divide datapath as above.
- MULDIV_DIV_EN undefined:
  - Divide logic is not compiled.
  - DIV/DIVU with start still complete: busy for one cycle, then done=1 with hilo_we=0 and result unchanged.
  - Multiply behaviour and latency are unchanged.

## Structure
- muldiv_pkg holds:
  - op encodings: MULT=2'b00, MULTU=2'b01, DIV=2'b10, DIVU=2'b11;
  - state enum;
  - ITER=32.
- Sub-module div_step: one combinational restoring-divide step (remainder, quotient, divisor in; next remainder and quotient out). It is instantiated only under MULDIV_DIV_EN.

## Test plan
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> at N+34: result=0xFFFFFFFE_00000001, one-cycle hilo_we.
- MULT a=0xFFFFFFFD (-3), b=7 -> result=0xFFFFFFFF_FFFFFFEB; MULT 0x80000000 x 0x80000000 -> 0x40000000_00000000.
- DIV a=-7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=100, b=7 -> lo=14, hi=2. DIV 0x80000000 / -1 -> lo=0x80000000, hi=0.
- DIVU a=0x1234, b=0 -> lo=0xFFFFFFFF, hi=0x1234, latency 34.
- start re-asserted at N+5 and at N+34 -> both ignored, exactly one done. Back-to-back start at N+35 -> accepted.
- rst at N+10 -> N+11: busy=0, result=0, no hilo_we ever issued. Without MULDIV_DIV_EN, DIV -> done at N+1, hilo_we=0.
